// File: rtl/mpt_pkg.sv
// Shared MPT walker types.
//   spa_t_u      : supervisor physical address
//   mmpt_reg_t   : MMPT register image (mode / sdid / ppn)
//   mpt_access_e : access type of a permission check
//   mptw_arb_req_t : one request held by the walker front-end arbiter
//   MPTW_ARB_PORT_* : conventional requestor port indices
package mpt_pkg;

    typedef logic [55:0] spa_t_u;

    typedef struct packed {
        logic [3:0]  mode;
        logic [5:0]  sdid;
        logic [43:0] ppn;
    } mmpt_reg_t;

    typedef enum logic [1:0] {
        MPT_ACCESS_READ  = 2'd0,
        MPT_ACCESS_WRITE = 2'd1,
        MPT_ACCESS_EXEC  = 2'd2
    } mpt_access_e;

    typedef struct packed {
        spa_t_u      spa;
        mmpt_reg_t   mmpt;
        mpt_access_e access;
    } mptw_arb_req_t;

    localparam int MPTW_ARB_PORT_FETCH = 0;
    localparam int MPTW_ARB_PORT_LSU   = 1;
    localparam int MPTW_ARB_PORT_DMA   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req   : request vector
//   i_ptr   : highest-priority index this cycle
//   o_gnt   : one-hot grant
//   o_idx   : index of the granted requestor
//   o_valid : some request was granted
module rr_arbiter #(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);
    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] w_dbl;
    logic [NUM_PORTS-1:0]   w_rot;
    logic [IDX_W-1:0]       w_off;
    logic [IDX_W:0]         w_sum;

    // Rotate so that i_ptr lands at bit 0, then take the lowest set bit.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_PORTS-1:0];

    always_comb begin
        w_off   = '0;
        o_valid = 1'b0;
        for (int j = NUM_PORTS-1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off   = IDX_W'(j);
                o_valid = 1'b1;
            end
        end
        // Undo the rotation: (ptr + offset) mod NUM_PORTS.
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= NP) w_sum = w_sum - NP;
        o_idx = w_sum[IDX_W-1:0];
        o_gnt = o_valid ? (NUM_PORTS'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/mptw_req_arbiter.sv
// MPT walker front-end: one holding slot per requestor, round-robin grant into a
// registered walker transaction port, and an in-flight credit limit.
//   clk_i / rst_i (async, active-high) / flush_i (sync, drops all state but rr_ptr)
//   mmpt_reg_i                  : MMPT snapshot captured with each accepted request
//   req_valid_i / req_ready_o   : per-port request handshake (ready is registered-only)
//   req_spa_i / req_access_i    : per-port request payload
//   mptw_valid_o / mptw_ready_i : walker transaction handshake
//   mptw_spa_o / mptw_mmpt_o / mptw_access_o / mptw_port_id_o : issued transaction
//   resp_done_i                 : walker retired one transaction
//   outstanding_o               : issued but not yet retired transactions
module mptw_req_arbiter
    import mpt_pkg::*;
#(
    parameter  int NUM_PORTS       = 2,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int PORT_ID_W       = $clog2(NUM_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  mmpt_reg_t                         mmpt_reg_i,
    input  logic        [NUM_PORTS-1:0]       req_valid_i,
    output logic        [NUM_PORTS-1:0]       req_ready_o,
    input  spa_t_u      [NUM_PORTS-1:0]       req_spa_i,
    input  mpt_access_e [NUM_PORTS-1:0]       req_access_i,
    output logic                              mptw_valid_o,
    input  logic                              mptw_ready_i,
    output spa_t_u                            mptw_spa_o,
    output mmpt_reg_t                         mptw_mmpt_o,
    output mpt_access_e                       mptw_access_o,
    output logic        [PORT_ID_W-1:0]       mptw_port_id_o,
    input  logic                              resp_done_i,
    output logic        [CNT_W-1:0]           outstanding_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic          [NUM_PORTS-1:0] r_slot_full;
    mptw_arb_req_t [NUM_PORTS-1:0] r_slot;
    logic                          r_valid;
    mptw_arb_req_t                 r_out;
    logic          [PORT_ID_W-1:0] r_port_id;
    logic          [PORT_ID_W-1:0] r_rr_ptr;
    logic          [CNT_W-1:0]     r_outstanding;

    logic [NUM_PORTS-1:0] w_acc;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [PORT_ID_W-1:0] w_gnt_idx;
    logic [PORT_ID_W-1:0] w_rr_next;
    logic                 w_gnt_any;
    logic                 w_out_free;
    logic                 w_credit;
    logic                 w_issue;
    logic                 w_done;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .i_req   (r_slot_full),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_any)
    );

    // Ready depends only on state and flush/reset, never on the walker side.
    assign req_ready_o = ~r_slot_full & {NUM_PORTS{!flush_i && !rst_i}};
    assign w_acc       = req_valid_i & req_ready_o;

    assign w_out_free = !r_valid || mptw_ready_i;
    assign w_credit   = r_outstanding < MAX_CNT;
    assign w_issue    = w_out_free && w_credit && w_gnt_any;
    // A completion with nothing in flight is dropped.
    assign w_done     = resp_done_i && (r_outstanding != '0);
    assign w_rr_next  = (w_gnt_idx == PORT_ID_W'(NUM_PORTS-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot_full <= '0;
            r_slot      <= '0;
        end else if (flush_i) begin
            r_slot_full <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_issue && w_gnt[i]) r_slot_full[i] <= 1'b0;
                if (w_acc[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot[i]      <= '{spa: req_spa_i[i], mmpt: mmpt_reg_i, access: req_access_i[i]};
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid       <= 1'b0;
            r_out         <= '0;
            r_port_id     <= '0;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
        end else if (flush_i) begin
            r_valid       <= 1'b0;
            r_outstanding <= '0;
        end else begin
            if (w_issue) begin
                r_valid   <= 1'b1;
                r_out     <= r_slot[w_gnt_idx];
                r_port_id <= w_gnt_idx;
                r_rr_ptr  <= w_rr_next;
            end else if (w_out_free) begin
                r_valid   <= 1'b0;
            end
            case ({w_issue, w_done})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign mptw_valid_o   = r_valid;
    assign mptw_spa_o     = r_out.spa;
    assign mptw_mmpt_o    = r_out.mmpt;
    assign mptw_access_o  = r_out.access;
    assign mptw_port_id_o = r_port_id;
    assign outstanding_o  = r_outstanding;

`ifndef SYNTHESIS
    logic          r_chk_hold;
    mptw_arb_req_t r_chk_out;
    logic [PORT_ID_W-1:0] r_chk_id;

    always_ff @(posedge clk_i) begin
        r_chk_hold <= !rst_i && !flush_i && r_valid && !mptw_ready_i;
        r_chk_out  <= r_out;
        r_chk_id   <= r_port_id;
        if (!rst_i && !flush_i) begin
            assert (!(w_issue && r_outstanding == MAX_CNT));
            assert (!(resp_done_i && r_outstanding == '0));
            for (int i = 0; i < NUM_PORTS; i++)
                assert (!(w_acc[i] && r_slot_full[i]));
        end
        if (r_chk_hold && !rst_i)
            assert (r_valid && r_out == r_chk_out && r_port_id == r_chk_id);
    end
`endif

endmodule

// File: tb/tb_mptw_req_arbiter.sv
module tb_mptw_req_arbiter;
    import mpt_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 4;
    localparam int IDW  = $clog2(N);
    localparam int CW   = $clog2(MAXO+1);

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 flush_i = 1'b0;
    mmpt_reg_t            mmpt_reg_i = '0;
    logic        [N-1:0]  req_valid_i = '0;
    logic        [N-1:0]  req_ready_o;
    spa_t_u      [N-1:0]  req_spa_i = '0;
    mpt_access_e [N-1:0]  req_access_i;
    logic                 mptw_valid_o;
    logic                 mptw_ready_i = 1'b0;
    spa_t_u               mptw_spa_o;
    mmpt_reg_t            mptw_mmpt_o;
    mpt_access_e          mptw_access_o;
    logic        [IDW-1:0] mptw_port_id_o;
    logic                 resp_done_i = 1'b0;
    logic        [CW-1:0] outstanding_o;

    mptw_req_arbiter #(.NUM_PORTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .mmpt_reg_i(mmpt_reg_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_spa_i(req_spa_i), .req_access_i(req_access_i),
        .mptw_valid_o(mptw_valid_o), .mptw_ready_i(mptw_ready_i),
        .mptw_spa_o(mptw_spa_o), .mptw_mmpt_o(mptw_mmpt_o),
        .mptw_access_o(mptw_access_o), .mptw_port_id_o(mptw_port_id_o),
        .resp_done_i(resp_done_i), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: a holding cell per port, one output register, a pointer, a count.
    mptw_arb_req_t m_slot[N];
    bit            m_full[N];
    mptw_arb_req_t m_out;
    bit            m_v;
    int            m_oid, m_rr, m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_full[i] = 0; m_slot[i] = '0; end
        m_out = '0; m_v = 0; m_oid = 0; m_rr = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit can_take[N];
        int g, c0;
        if (rst_i) begin model_reset(); return; end
        if (flush_i) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_v = 0; m_cnt = 0;
            return;
        end
        for (int i = 0; i < N; i++) can_take[i] = !m_full[i];
        c0 = m_cnt;
        g = -1;
        if ((!m_v || mptw_ready_i) && m_cnt < MAXO)
            for (int k = N-1; k >= 0; k--)
                if (m_full[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) begin
            m_out = m_slot[g]; m_oid = g; m_v = 1; m_full[g] = 0;
            m_rr = (g + 1) % N; m_cnt++;
        end else if (!m_v || mptw_ready_i) begin
            m_v = 0;
        end
        if (resp_done_i && c0 > 0) m_cnt--;
        for (int i = 0; i < N; i++)
            if (req_valid_i[i] && can_take[i]) begin
                m_full[i] = 1;
                m_slot[i] = '{spa: req_spa_i[i], mmpt: mmpt_reg_i, access: req_access_i[i]};
            end
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = !m_full[i] && !flush_i && !rst_i;
        chk("ready", 64'(req_ready_o), 64'(er));
        chk("valid", 64'(mptw_valid_o), 64'(m_v));
        chk("outstanding", 64'(outstanding_o), 64'(m_cnt));
        if (m_v) begin
            chk("spa", 64'(mptw_spa_o), 64'(m_out.spa));
            chk("mmpt", 64'(mptw_mmpt_o), 64'(m_out.mmpt));
            chk("access", 64'(mptw_access_o), 64'(m_out.access));
            chk("port_id", 64'(mptw_port_id_o), 64'(m_oid));
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are checked 1ns later.
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic spa_t_u rnd_spa();
        return spa_t_u'({$urandom(), $urandom()});
    endfunction

    task automatic rnd_payload();
        for (int i = 0; i < N; i++) begin
            req_spa_i[i]    = rnd_spa();
            req_access_i[i] = mpt_access_e'(2'($urandom_range(0, 2)));
        end
        mmpt_reg_i = mmpt_reg_t'({$urandom(), $urandom()});
    endtask

    initial begin
        int q[$];
        int n_iss, s_id;
        spa_t_u s_spa;

        for (int i = 0; i < N; i++) req_access_i[i] = MPT_ACCESS_READ;
        mmpt_reg_i = '{mode: 4'h9, sdid: 6'h15, ppn: 44'h123_4567_89AB};

        // Reset held three cycles with both requestors asking.
        #2 rst_i = 1'b1;
        model_reset();
        req_valid_i = 2'b11;
        repeat (3) tick();
        chk("t1_rst_ready", 64'(req_ready_o), 64'h0);
        chk("t1_rst_valid", 64'(mptw_valid_o), 64'h0);
        chk("t1_rst_cnt", 64'(outstanding_o), 64'h0);
        rst_i = 1'b0;
        req_valid_i = '0;
        #1 chk("t1_rel_ready", 64'(req_ready_o), 64'h3);

        // Single request from port 1, visible two cycles after acceptance.
        mptw_ready_i = 1'b1;
        req_valid_i  = 2'b10;
        req_spa_i[1] = 56'h8000_1000;
        req_access_i[1] = MPT_ACCESS_READ;
        tick();
        req_valid_i = '0;
        tick();
        chk("t2_valid", 64'(mptw_valid_o), 64'h1);
        chk("t2_spa", 64'(mptw_spa_o), 64'h8000_1000);
        chk("t2_access", 64'(mptw_access_o), 64'(MPT_ACCESS_READ));
        chk("t2_port", 64'(mptw_port_id_o), 64'h1);
        chk("t2_cnt", 64'(outstanding_o), 64'h1);
        resp_done_i = 1'b1;
        tick();
        resp_done_i = 1'b0;
        tick();
        chk("t2_drain", 64'(outstanding_o), 64'h0);

        // Both ports saturated: grants must alternate.
        req_valid_i = 2'b11;
        for (int c = 0; c < 20; c++) begin
            rnd_payload();
            resp_done_i = (m_cnt > 0);
            tick();
            if (mptw_valid_o) q.push_back(int'(mptw_port_id_o));
        end
        chk("t3_count", 64'(q.size() >= 16), 64'h1);
        for (int k = 1; k < q.size(); k++)
            chk("t3_alternate", 64'(q[k]), 64'(1 - q[k-1]));
        req_valid_i = '0;
        for (int c = 0; c < 8; c++) begin
            resp_done_i = (m_cnt > 0);
            tick();
        end
        resp_done_i = 1'b0;
        chk("t4_pre_cnt", 64'(outstanding_o), 64'h0);

        // Credit limit: no completions, only MAXO issues.
        n_iss = 0;
        req_valid_i = 2'b11;
        for (int c = 0; c < 16; c++) begin
            rnd_payload();
            tick();
            if (mptw_valid_o) n_iss++;
        end
        chk("t4_issues", 64'(n_iss), 64'(MAXO));
        chk("t4_stall_valid", 64'(mptw_valid_o), 64'h0);
        chk("t4_full_cnt", 64'(outstanding_o), 64'(MAXO));
        resp_done_i = 1'b1;
        tick();
        resp_done_i = 1'b0;
        tick();
        chk("t4_fifth", 64'(mptw_valid_o), 64'h1);
        chk("t4_fifth_cnt", 64'(outstanding_o), 64'(MAXO));

        // Backpressure: outputs frozen, slots still refill.
        s_spa = m_out.spa;
        s_id  = m_oid;
        mptw_ready_i = 1'b0;
        resp_done_i  = 1'b1;
        repeat (2) tick();
        resp_done_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rnd_payload();
            tick();
            chk("t5_hold_valid", 64'(mptw_valid_o), 64'h1);
            chk("t5_hold_spa", 64'(mptw_spa_o), 64'(s_spa));
            chk("t5_hold_id", 64'(mptw_port_id_o), 64'(s_id));
        end
        chk("t5_slots_full", 64'(req_ready_o), 64'h0);
        mptw_ready_i = 1'b1;
        tick();
        chk("t5_next_valid", 64'(mptw_valid_o), 64'h1);
        chk("t5_next_id", 64'(mptw_port_id_o), 64'((s_id + 1) % N));

        // Flush with everything busy; a same-cycle completion is discarded.
        mptw_ready_i = 1'b0;
        tick();
        chk("t6_pre_cnt", 64'(outstanding_o), 64'h3);
        chk("t6_pre_full", 64'(req_ready_o), 64'h0);
        flush_i = 1'b1;
        resp_done_i = 1'b1;
        tick();
        flush_i = 1'b0;
        resp_done_i = 1'b0;
        req_valid_i = '0;
        #1;
        chk("t6_valid", 64'(mptw_valid_o), 64'h0);
        chk("t6_cnt", 64'(outstanding_o), 64'h0);
        chk("t6_ready", 64'(req_ready_o), 64'h3);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rnd_payload();
            req_valid_i  = N'($urandom());
            mptw_ready_i = ($urandom_range(0, 9) < 7);
            resp_done_i  = (m_cnt > 0) && ($urandom_range(0, 9) < 4);
            flush_i      = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush_i = 1'b0;
        resp_done_i = 1'b0;
        req_valid_i = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
